ddr_sdram_responder: RTL
========================

Name: ddr_sdram_responder

Overview:
- Synthesizable device-side responder for the SDRAM command/data interface driven by the DDR controller.
- Decodes registered CS_N/RAS_N/CAS_N/WE_N/SA/BA commands and tracks mode register, per-bank open rows, read/write bursts and refresh count.
- Backs data with a small internal memory and flags protocol violations.
- Used as the bench/loopback target for the controller on a single clock. Data runs at one beat per CLK (split DQ_I/DQ_O/DQ_OE, no inout).

Parameters:
- DW, 16, data beat width (DQM width = DW/8)
- ROW_BITS, 2, low row bits used for memory indexing
- COL_BITS, 6, column bits used for memory indexing (SA[COL_BITS-1:0])
- CS_IDX, 0, which CS_N bit selects this device
- TRCD, 2, ACTIVE-to-READ/WRITE minimum cycles (checked only with the optional feature)

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- SA  in  12  address
- BA  in  2  bank
- CS_N  in  2  chip selects
- CKE  in  1  clock enable
- RAS_N, CAS_N, WE_N  in  1 each  command
- DQM  in  DW/8  write byte mask, 1 = masked
- DQ_I  in  DW  write data
- DQ_O  out  DW  read data
- DQ_OE  out  1  read data valid/drive enable
- ERR  out  1  sticky violation flag
- ERR_CODE  out  3  code of first violation
- OPEN_BANKS  out  4  per-bank row-open flags
- REF_CNT  out  16  saturating count of accepted REFRESH commands

Behaviour:
- Reset (async, RESET_N low): DQ_O=0, DQ_OE=0, ERR=0, ERR_CODE=0, OPEN_BANKS=0, REF_CNT=0, CL=2, BL=2, bursts idle. Memory contents are not reset.
- Command sampled on posedge CLK only when CS_N[CS_IDX]=0. RAS,CAS,WE decode:
  - 000 LOAD_MODE
  - 001 REFRESH
  - 010 PRECHARGE
  - 011 ACTIVE
  - 100 WRITE
  - 101 READ
  - 110 BURST_STOP
  - 111 NOP
- CKE=0: any non-NOP selected command -> error 5; command ignored.
- LOAD_MODE:
  - BA=00 only; other BA values are ignored.
  - SA[2:0]: 1 -> BL=2, 2 -> BL=4, 3 -> BL=8. SA[6:4]: 2 or 3 -> CL.
  - Any other BL or CL value -> error 6; mode is unchanged.
  - Any bank open -> error 4; mode is unchanged.
- ACTIVE:
  - Bank already open -> error 1, row unchanged.
  - Otherwise latch row SA[ROW_BITS-1:0] and set OPEN_BANKS[BA].
- PRECHARGE: SA[10]=1 closes all banks; else closes bank BA. Precharging an idle bank is legal.
- REFRESH: any bank open -> error 4; else REF_CNT+1, saturating at 0xFFFF.
- READ/WRITE:
  - Bank closed -> error 2.
  - Read or write burst active, including CL wait -> error 3; command ignored.
  - Memory index = {BA, row, col}. Burst address wraps sequentially inside the BL-aligned column block. Example: col 5, BL=4 -> 5,6,7,4.
- READ issued at edge t: DQ_O/DQ_OE valid on beats t+CL .. t+CL+BL-1, registered. DQ_OE low otherwise.
- WRITE issued at edge t: DQ_I sampled at edges t+1 .. t+BL. Each byte lane with DQM bit=1 is not written.
- SA[10]=1 on READ/WRITE (auto-precharge): bank closes on the edge of the last beat.
- BURST_STOP: terminates the active read after the current beat (DQ_OE low next cycle) or stops the remaining write beats. With no burst active it is a NOP.
- Error handling: ERR sets on the first violation and stays set until reset. ERR_CODE holds the first code; later violations do not overwrite it.
- Simultaneous events: a PRECHARGE to the bank of an in-flight burst closes the bank immediately; the burst still completes its data beats.
- Reset mid-burst aborts it; DQ_OE drops asynchronously.

Optional Feature:
- Macro DDR_RESP_TRCD_CHECK_EN.
- Defined: a per-bank counter is loaded with TRCD on ACTIVE. A READ/WRITE to that bank before TRCD cycles have elapsed -> error 7; the command is still executed.
- Undefined: no counter logic; code 7 is never produced.

Test Plan:
- Reset, then LOAD_MODE SA=0x023 (CL=2, BL=8) -> no error. ACTIVE BA=1 row=2 -> OPEN_BANKS=0010.
- WRITE BA=1 col=0, DQ_I=0x1111..0x8888 over 8 beats, DQM=0. Then READ col=0 -> DQ_OE high for exactly 8 cycles starting 2 cycles after READ, data 0x1111..0x8888 in order.
- BL=4, WRITE col=5 with DQM=01 on 2nd beat. Read back col=4 -> beat order/wrap as specified; low byte of col 6 keeps its old value.
- READ to closed bank 3 -> ERR=1, ERR_CODE=2. Then ACTIVE to open bank 1 -> ERR_CODE stays 2.
- REFRESH with bank 1 open -> error 4, REF_CNT=0. PRECHARGE SA[10]=1, then 3 REFRESHes -> REF_CNT=3, OPEN_BANKS=0.
- With DDR_RESP_TRCD_CHECK_EN: ACTIVE then READ on the next cycle (TRCD=2) -> ERR_CODE=7, read data still returned. Same stimulus with the macro undefined -> ERR=0.

Source files
------------

// File: rtl/ddr_sdram_responder_if.sv
// Command/data bus between the DDR controller (master) and the SDRAM responder (slave).
interface ddr_sdram_responder_if #(
  parameter int unsigned DW = 16
);
  logic [11:0]     SA;
  logic [1:0]      BA;
  logic [1:0]      CS_N;
  logic            CKE;
  logic            RAS_N;
  logic            CAS_N;
  logic            WE_N;
  logic [DW/8-1:0] DQM;
  logic [DW-1:0]   DQ_I;
  logic [DW-1:0]   DQ_O;
  logic            DQ_OE;
  logic            ERR;
  logic [2:0]      ERR_CODE;
  logic [3:0]      OPEN_BANKS;
  logic [15:0]     REF_CNT;

  modport master (
    output SA, BA, CS_N, CKE, RAS_N, CAS_N, WE_N, DQM, DQ_I,
    input  DQ_O, DQ_OE, ERR, ERR_CODE, OPEN_BANKS, REF_CNT
  );

  modport slave (
    input  SA, BA, CS_N, CKE, RAS_N, CAS_N, WE_N, DQM, DQ_I,
    output DQ_O, DQ_OE, ERR, ERR_CODE, OPEN_BANKS, REF_CNT
  );
endinterface

// File: rtl/ddr_sdram_responder.sv
// Device-side SDRAM responder: decodes controller commands, tracks mode, open rows,
// bursts and refreshes, backs data with a small memory and latches the first
// protocol violation. Optional ACTIVE-to-READ/WRITE check: DDR_RESP_TRCD_CHECK_EN.
module ddr_sdram_responder #(
  parameter int unsigned DW       = 16,
  parameter int unsigned ROW_BITS = 2,
  parameter int unsigned COL_BITS = 6,
  parameter int unsigned CS_IDX   = 0,
  parameter int unsigned TRCD     = 2
) (
  input logic                  CLK,
  input logic                  RESET_N,
  ddr_sdram_responder_if.slave bus
);
  localparam int unsigned NB    = DW / 8;
  localparam int unsigned AW    = 2 + ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    CmdLoadMode  = 3'b000,
    CmdRefresh   = 3'b001,
    CmdPrecharge = 3'b010,
    CmdActive    = 3'b011,
    CmdWrite     = 3'b100,
    CmdRead      = 3'b101,
    CmdBurstStop = 3'b110,
    CmdNop       = 3'b111
  } cmd_e;

  logic [DW-1:0]       mem [DEPTH];
  logic [1:0]          cl_q;
  logic [3:0]          bl_q;
  logic [3:0]          open_q, open_d;
  logic [ROW_BITS-1:0] row_q [4];
  logic [15:0]         ref_cnt_q;
  logic                err_q;
  logic [2:0]          err_code_q;
  logic [DW-1:0]       dq_o_q;
  logic                dq_oe_q;

  // Burst context is latched at issue so a mid-burst PRECHARGE cannot disturb it.
  logic                rd_act_q, rd_ap_q, wr_act_q, wr_ap_q;
  logic [1:0]          rd_wait_q, rd_bank_q, wr_bank_q;
  logic [3:0]          rd_beat_q, rd_bl_q, wr_beat_q, wr_bl_q;
  logic [ROW_BITS-1:0] rd_row_q, wr_row_q;
  logic [COL_BITS-1:0] rd_col_q, wr_col_q;

  cmd_e       cmd;
  logic       cmd_v, cl_ok, trcd_viol;
  logic [3:0] mode_bl;
  logic       err_hit;
  logic [2:0] err_val;
  logic       ld_mode, do_act, do_pre, do_ref, do_rd, do_wr, do_stop;
  logic       rd_fire, rd_last, wr_fire, wr_last;
  logic [AW-1:0] rd_addr, wr_addr;

  // Sequential wrap inside the BL-aligned column block.
  function automatic logic [COL_BITS-1:0] burst_col(input logic [COL_BITS-1:0] c0,
                                                    input logic [3:0] beat,
                                                    input logic [3:0] bl);
    logic [COL_BITS-1:0] m;
    m = COL_BITS'(bl - 4'd1);
    return (c0 & ~m) | ((c0 + COL_BITS'(beat)) & m);
  endfunction

  assign cmd     = cmd_e'({bus.RAS_N, bus.CAS_N, bus.WE_N});
  assign cmd_v   = !bus.CS_N[CS_IDX] && (cmd != CmdNop);
  assign cl_ok   = (bus.SA[6:4] == 3'd2) || (bus.SA[6:4] == 3'd3);
  assign rd_fire = rd_act_q && (rd_wait_q == 2'd0) && !do_stop;
  assign rd_last = rd_fire && (rd_beat_q == rd_bl_q - 4'd1);
  assign wr_fire = wr_act_q && !do_stop;
  assign wr_last = wr_fire && (wr_beat_q == wr_bl_q - 4'd1);
  assign rd_addr = {rd_bank_q, rd_row_q, burst_col(rd_col_q, rd_beat_q, rd_bl_q)};
  assign wr_addr = {wr_bank_q, wr_row_q, burst_col(wr_col_q, wr_beat_q, wr_bl_q)};

  // Command decode and violation detection for the current edge.
  always_comb begin
    mode_bl = 4'd0;
    unique case (bus.SA[2:0])
      3'd1:    mode_bl = 4'd2;
      3'd2:    mode_bl = 4'd4;
      3'd3:    mode_bl = 4'd8;
      default: mode_bl = 4'd0;
    endcase
    err_hit = 1'b0;
    err_val = 3'd0;
    ld_mode = 1'b0;
    do_act  = 1'b0;
    do_pre  = 1'b0;
    do_ref  = 1'b0;
    do_rd   = 1'b0;
    do_wr   = 1'b0;
    do_stop = 1'b0;
    if (cmd_v && !bus.CKE) begin
      err_hit = 1'b1;
      err_val = 3'd5;
    end else if (cmd_v) begin
      case (cmd)
        CmdLoadMode: if (bus.BA == 2'd0) begin
          if (|open_q) begin
            err_hit = 1'b1;
            err_val = 3'd4;
          end else if (mode_bl == 4'd0 || !cl_ok) begin
            err_hit = 1'b1;
            err_val = 3'd6;
          end else begin
            ld_mode = 1'b1;
          end
        end
        CmdRefresh: if (|open_q) begin
          err_hit = 1'b1;
          err_val = 3'd4;
        end else begin
          do_ref = 1'b1;
        end
        CmdPrecharge: do_pre = 1'b1;
        CmdActive: if (open_q[bus.BA]) begin
          err_hit = 1'b1;
          err_val = 3'd1;
        end else begin
          do_act = 1'b1;
        end
        CmdWrite, CmdRead: begin
          if (!open_q[bus.BA]) begin
            err_hit = 1'b1;
            err_val = 3'd2;
          end else if (rd_act_q || wr_act_q) begin
            err_hit = 1'b1;
            err_val = 3'd3;
          end else begin
            do_rd = (cmd == CmdRead);
            do_wr = (cmd == CmdWrite);
            if (trcd_viol) begin
              err_hit = 1'b1;
              err_val = 3'd7;
            end
          end
        end
        CmdBurstStop: do_stop = rd_act_q || wr_act_q;
        default: ;
      endcase
    end
  end

  // Bank state: auto-precharge and PRECHARGE close, ACTIVE opens.
  always_comb begin
    open_d = open_q;
    if (rd_last && rd_ap_q) open_d[rd_bank_q] = 1'b0;
    if (wr_last && wr_ap_q) open_d[wr_bank_q] = 1'b0;
    if (do_pre) begin
      if (bus.SA[10]) open_d = 4'd0;
      else            open_d[bus.BA] = 1'b0;
    end
    if (do_act) open_d[bus.BA] = 1'b1;
  end

`ifdef DDR_RESP_TRCD_CHECK_EN
  localparam logic [3:0] TrcdLoad = (TRCD > 0) ? 4'(TRCD - 1) : 4'd0;
  logic [3:0] trcd_q [4];

  // Per-bank countdown from ACTIVE; nonzero means the row is not yet usable.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) trcd_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (do_act && bus.BA == 2'(i)) trcd_q[i] <= TrcdLoad;
        else if (trcd_q[i] != 4'd0)    trcd_q[i] <= trcd_q[i] - 4'd1;
      end
    end
  end
  assign trcd_viol = (trcd_q[bus.BA] != 4'd0);
`else
  localparam int unsigned unused_trcd = TRCD;
  assign trcd_viol = 1'b0;
`endif

  // Backing store: write beats with per-byte DQM masking; never reset.
  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (!bus.DQM[b]) mem[wr_addr][b*8 +: 8] <= bus.DQ_I[b*8 +: 8];
      end
    end
  end

  // Mode, bank, refresh, error and burst sequencing state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cl_q       <= 2'd2;
      bl_q       <= 4'd2;
      open_q     <= 4'd0;
      for (int i = 0; i < 4; i++) row_q[i] <= '0;
      ref_cnt_q  <= 16'd0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      dq_o_q     <= '0;
      dq_oe_q    <= 1'b0;
      rd_act_q   <= 1'b0;
      rd_ap_q    <= 1'b0;
      rd_wait_q  <= 2'd0;
      rd_beat_q  <= 4'd0;
      rd_bl_q    <= 4'd2;
      rd_bank_q  <= 2'd0;
      rd_row_q   <= '0;
      rd_col_q   <= '0;
      wr_act_q   <= 1'b0;
      wr_ap_q    <= 1'b0;
      wr_beat_q  <= 4'd0;
      wr_bl_q    <= 4'd2;
      wr_bank_q  <= 2'd0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
    end else begin
      if (ld_mode) begin
        cl_q <= bus.SA[5:4];
        bl_q <= mode_bl;
      end
      open_q <= open_d;
      if (do_act) row_q[bus.BA] <= bus.SA[ROW_BITS-1:0];
      if (do_ref && ref_cnt_q != 16'hFFFF) ref_cnt_q <= ref_cnt_q + 16'd1;
      if (err_hit && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= err_val;
      end
      dq_oe_q <= rd_fire;
      dq_o_q  <= rd_fire ? mem[rd_addr] : '0;
      if (do_rd) begin
        rd_act_q  <= 1'b1;
        rd_ap_q   <= bus.SA[10];
        rd_wait_q <= cl_q - 2'd1;
        rd_beat_q <= 4'd0;
        rd_bl_q   <= bl_q;
        rd_bank_q <= bus.BA;
        rd_row_q  <= row_q[bus.BA];
        rd_col_q  <= bus.SA[COL_BITS-1:0];
      end else if (rd_act_q) begin
        if (do_stop)                rd_act_q  <= 1'b0;
        else if (rd_wait_q != 2'd0) rd_wait_q <= rd_wait_q - 2'd1;
        else begin
          rd_beat_q <= rd_beat_q + 4'd1;
          if (rd_last) rd_act_q <= 1'b0;
        end
      end
      if (do_wr) begin
        wr_act_q  <= 1'b1;
        wr_ap_q   <= bus.SA[10];
        wr_beat_q <= 4'd0;
        wr_bl_q   <= bl_q;
        wr_bank_q <= bus.BA;
        wr_row_q  <= row_q[bus.BA];
        wr_col_q  <= bus.SA[COL_BITS-1:0];
      end else if (wr_act_q) begin
        if (do_stop) wr_act_q <= 1'b0;
        else begin
          wr_beat_q <= wr_beat_q + 4'd1;
          if (wr_last) wr_act_q <= 1'b0;
        end
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.SA, bus.CS_N};

  assign bus.DQ_O       = dq_o_q;
  assign bus.DQ_OE      = dq_oe_q;
  assign bus.ERR        = err_q;
  assign bus.ERR_CODE   = err_code_q;
  assign bus.OPEN_BANKS = open_q;
  assign bus.REF_CNT    = ref_cnt_q;
endmodule
